// File: rtl/systolic_block_sequencer.sv
// rtl/systolic_block_sequencer.sv - host-side block sequencer for a 4-bit-lane systolic tile
module systolic_block_sequencer #(
  parameter int LEN_W           = 8,
  parameter int TILE_RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_blocks,
  output logic             busy,
  output logic             done,
  input  logic [15:0]      in_col_word,
  input  logic [15:0]      in_row_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tile_rst_n,
  output logic [3:0]       tile_col,
  output logic [3:0]       tile_row,
  output logic             tile_col_ctrl,
  output logic             tile_row_ctrl,
  input  logic [3:0]       tile_col_o,
  input  logic [3:0]       tile_row_o,
  input  logic             tile_col_ctrl_o,
  output logic [15:0]      out_col_word,
  output logic [15:0]      out_row_word,
  output logic             out_valid,
  output logic [LEN_W-1:0] underrun_cnt
);

  localparam int TW = (TILE_RST_CYCLES > 1) ? $clog2(TILE_RST_CYCLES) : 1;
  localparam logic [TW-1:0] TRST_LAST = TW'(TILE_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRST,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       phase;
  logic [TW-1:0]    trst_cnt;

  logic [LEN_W-1:0] nblk_q;
  logic [LEN_W-1:0] accepted_cnt;
  logic [LEN_W-1:0] loaded_cnt;
  logic [LEN_W:0]   loaded_plus1;

  logic             hold_full;
  logic [15:0]      hold_col;
  logic [15:0]      hold_row;

  logic [15:0]      cur_col;
  logic [15:0]      cur_row;
  logic             cur_real;
  logic             cur_last;

  logic [15:0]      ret_col;
  logic [15:0]      ret_row;
  logic             ret_ctrl0;

  logic             load_blk;
  logic             accept;
  logic             load_real;
  logic             load_last;
  logic             streaming;
  logic             active;
  logic [15:0]      src_col;
  logic [15:0]      src_row;
  logic [3:0]       nib_idx;

  // Next state; load_blk marks the edge where the next block enters the shift register
  always_comb begin
    state_next = state;
    load_blk   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_TRST;
      end
      S_TRST: begin
        if (trst_cnt == TRST_LAST) begin
          if (nblk_q == '0) begin
            state_next = S_DRAIN;
          end else begin
            state_next = S_STREAM;
            load_blk   = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (phase == 2'd3) begin
          if (cur_last) state_next = S_DRAIN;
          else          load_blk   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (phase == 2'd3) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake, block source selection and tile lane drive
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    in_ready     = busy && !hold_full && (accepted_cnt < nblk_q);
    accept       = in_valid && in_ready;
    // a word arriving on the load edge itself skips the holding register
    load_real    = load_blk && (hold_full || accept);
    src_col      = hold_full ? hold_col : in_col_word;
    src_row      = hold_full ? hold_row : in_row_word;
    loaded_plus1 = {1'b0, loaded_cnt} + {{LEN_W{1'b0}}, 1'b1};
    load_last    = (loaded_plus1 == {1'b0, nblk_q});
    streaming    = (state == S_STREAM);
    active       = streaming || (state == S_DRAIN);
    // phase p addresses bits [15-4p -: 4], MSB nibble first
    nib_idx      = {~phase, 2'b11};
    tile_col     = streaming ? cur_col[nib_idx -: 4] : 4'd0;
    tile_row     = streaming ? cur_row[nib_idx -: 4] : 4'd0;
    tile_col_ctrl = streaming && cur_real &&
                    ((phase == 2'd0) || ((phase == 2'd1) && cur_last));
    tile_row_ctrl = tile_col_ctrl;
  end

  // State register, tile reset timer and block phase (phase follows the tile's block counter)
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= 2'd0;
      trst_cnt   <= '0;
      tile_rst_n <= 1'b0;
    end else begin
      state      <= state_next;
      tile_rst_n <= (state_next != S_TRST);
      phase      <= active ? (phase + 2'd1) : 2'd0;
      trst_cnt   <= (state == S_TRST) ? (trst_cnt + TW'(1)) : '0;
    end
  end

  // Job bookkeeping: holding register, block loader, bubble insertion and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      nblk_q       <= '0;
      accepted_cnt <= '0;
      loaded_cnt   <= '0;
      underrun_cnt <= '0;
      hold_full    <= 1'b0;
      hold_col     <= 16'd0;
      hold_row     <= 16'd0;
      cur_col      <= 16'd0;
      cur_row      <= 16'd0;
      cur_real     <= 1'b0;
      cur_last     <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        nblk_q       <= num_blocks;
        accepted_cnt <= '0;
        loaded_cnt   <= '0;
        underrun_cnt <= '0;
        hold_full    <= 1'b0;
        cur_col      <= 16'd0;
        cur_row      <= 16'd0;
        cur_real     <= 1'b0;
        cur_last     <= 1'b0;
      end
    end else begin
      if (accept) accepted_cnt <= accepted_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
      if (load_blk) begin
        hold_full <= 1'b0;
        if (load_real) begin
          cur_col    <= src_col;
          cur_row    <= src_row;
          cur_real   <= 1'b1;
          cur_last   <= load_last;
          loaded_cnt <= loaded_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          // the tile cannot stall, so an empty slot becomes a bubble block
          cur_col  <= 16'd0;
          cur_row  <= 16'd0;
          cur_real <= 1'b0;
          cur_last <= 1'b0;
          if (underrun_cnt != {LEN_W{1'b1}}) begin
            underrun_cnt <= underrun_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_col  <= in_col_word;
        hold_row  <= in_row_word;
      end
    end
  end

  // Return path: gather the previous block's nibbles and publish a word on each phase 3
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_col      <= 16'd0;
      ret_row      <= 16'd0;
      ret_ctrl0    <= 1'b0;
      out_col_word <= 16'd0;
      out_row_word <= 16'd0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (active) begin
        ret_col[nib_idx -: 4] <= tile_col_o;
        ret_row[nib_idx -: 4] <= tile_row_o;
        if (phase == 2'd0) ret_ctrl0 <= tile_col_ctrl_o;
        if (phase == 2'd3) begin
          out_col_word <= {ret_col[15:4], tile_col_o};
          out_row_word <= {ret_row[15:4], tile_row_o};
          out_valid    <= ret_ctrl0;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_block_sequencer.sv
// tb/tb_systolic_block_sequencer.sv - randomized self-checking bench for systolic_block_sequencer
module tb_systolic_block_sequencer;

  localparam int LEN_W = 8;
  localparam int TRC   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] num_blocks;
  logic             busy;
  logic             done;
  logic [15:0]      in_col_word;
  logic [15:0]      in_row_word;
  logic             in_valid;
  logic             in_ready;
  logic             tile_rst_n;
  logic [3:0]       tile_col;
  logic [3:0]       tile_row;
  logic             tile_col_ctrl;
  logic             tile_row_ctrl;
  logic [3:0]       tile_col_o;
  logic [3:0]       tile_row_o;
  logic             tile_col_ctrl_o;
  logic [15:0]      out_col_word;
  logic [15:0]      out_row_word;
  logic             out_valid;
  logic [LEN_W-1:0] underrun_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_block_sequencer #(
    .LEN_W           (LEN_W),
    .TILE_RST_CYCLES (TRC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_blocks      (num_blocks),
    .busy            (busy),
    .done            (done),
    .in_col_word     (in_col_word),
    .in_row_word     (in_row_word),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .tile_rst_n      (tile_rst_n),
    .tile_col        (tile_col),
    .tile_row        (tile_row),
    .tile_col_ctrl   (tile_col_ctrl),
    .tile_row_ctrl   (tile_row_ctrl),
    .tile_col_o      (tile_col_o),
    .tile_row_o      (tile_row_o),
    .tile_col_ctrl_o (tile_col_ctrl_o),
    .out_col_word    (out_col_word),
    .out_row_word    (out_row_word),
    .out_valid       (out_valid),
    .underrun_cnt    (underrun_cnt)
  );

  // Behavioural tile: each lane is a 4-cycle delay line, cleared while tile_rst_n is low
  logic [3:0] pc [4];
  logic [3:0] pr [4];
  logic       pk [4];

  always @(posedge clk) begin
    if (!tile_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pc[i] <= 4'd0;
        pr[i] <= 4'd0;
        pk[i] <= 1'b0;
      end
    end else begin
      pc[0] <= tile_col;
      pr[0] <= tile_row;
      pk[0] <= tile_col_ctrl;
      for (int i = 1; i < 4; i++) begin
        pc[i] <= pc[i-1];
        pr[i] <= pr[i-1];
        pk[i] <= pk[i-1];
      end
    end
  end

  assign tile_col_o      = pc[3];
  assign tile_row_o      = pr[3];
  assign tile_col_ctrl_o = pk[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One job, cycle c = 0 is the cycle where start is presented.
  // Reference: blocks begin every 4 cycles from t0; a block is real iff an accepted
  // word is waiting when it begins; a real block returns 8 cycles after it begins;
  // done follows the last real block by 8 cycles (n = 0: t0 + 4).
  task automatic run_job(input int n, input int prob, input int gap_lo, input int gap_hi,
                         input bit fixed_first, input int busy_start_at, input int rst_at);
    int          t0         = 1 + TRC;
    int          done_at    = 1 << 30;
    int          s_next     = 1 + TRC;
    int          blk_start  = -100;
    int          real_cnt   = 0;
    int          bubble_cnt = 0;
    int          used       = 0;
    int          p;
    bit          cur_real   = 1'b0;
    bit          cur_last   = 1'b0;
    bit          in_blk;
    bit          exp_ctrl;
    bit          pend       = 1'b0;
    logic [15:0] cur_col    = 16'd0;
    logic [15:0] cur_row    = 16'd0;
    logic [15:0] pend_col   = 16'd0;
    logic [15:0] pend_row   = 16'd0;
    logic [15:0] sh;
    logic [15:0] acc_col [$];
    logic [15:0] acc_row [$];
    int          ov_cyc  [$];
    logic [15:0] ov_col  [$];
    logic [15:0] ov_row  [$];

    if (n == 0) done_at = t0 + 4;
    for (int c = 0; c <= done_at + 1; c++) begin
      @(negedge clk);
      if (c > 3000) begin
        chk("job_timeout", 32'd1, 32'd0);
        break;
      end

      if (c >= t0 && c == s_next && real_cnt < n) begin
        blk_start = c;
        s_next    = c + 4;
        if (acc_col.size() > used) begin
          cur_real = 1'b1;
          cur_col  = acc_col[used];
          cur_row  = acc_row[used];
          used++;
          real_cnt++;
          cur_last = (real_cnt == n);
          ov_cyc.push_back(c + 8);
          ov_col.push_back(cur_col);
          ov_row.push_back(cur_row);
          if (cur_last) done_at = c + 8;
        end else begin
          cur_real = 1'b0;
          cur_last = 1'b0;
          cur_col  = 16'd0;
          cur_row  = 16'd0;
          bubble_cnt++;
        end
      end
      in_blk = (c >= blk_start) && (c < blk_start + 4);
      p      = c - blk_start;

      chk("busy", busy, (c >= 1 && c <= done_at));
      chk("done", done, (c == done_at));
      chk("tile_rst_n", tile_rst_n, !(c >= 1 && c <= TRC));
      chk("in_ready", in_ready,
          (c >= 1 && c <= done_at && acc_col.size() == used && acc_col.size() < n));
      sh = in_blk ? (cur_col >> (12 - 4 * p)) : 16'h0;
      chk("tile_col", tile_col, sh[3:0]);
      sh = in_blk ? (cur_row >> (12 - 4 * p)) : 16'h0;
      chk("tile_row", tile_row, sh[3:0]);
      exp_ctrl = in_blk && cur_real && (p == 0 || (p == 1 && cur_last));
      chk("tile_col_ctrl", tile_col_ctrl, exp_ctrl);
      chk("tile_row_ctrl", tile_row_ctrl, exp_ctrl);
      if (c >= 1) chk("underrun_cnt", underrun_cnt, bubble_cnt);
      if (ov_cyc.size() > 0 && ov_cyc[0] == c) begin
        chk("out_valid", out_valid, 1'b1);
        chk("out_col_word", out_col_word, ov_col[0]);
        chk("out_row_word", out_row_word, ov_row[0]);
        void'(ov_cyc.pop_front());
        void'(ov_col.pop_front());
        void'(ov_row.pop_front());
      end else begin
        chk("out_valid", out_valid, 1'b0);
      end

      if (c == rst_at) begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_tile_rst_n", tile_rst_n, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_underrun", underrun_cnt, 0);
        chk("abort_tile_col", tile_col, 0);
        chk("abort_ctrl", tile_col_ctrl, 1'b0);
        chk("abort_out_col_word", out_col_word, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_release_tile_rst_n", tile_rst_n, 1'b1);
        chk("abort_release_busy", busy, 1'b0);
        return;
      end

      start      = (c == 0) || (c == busy_start_at);
      num_blocks = (c == 0) ? LEN_W'(n) : LEN_W'($urandom_range(0, 255));
      if (!pend) begin
        if (fixed_first && acc_col.size() == 0) begin
          pend_col = 16'h1234;
          pend_row = 16'hABCD;
        end else begin
          pend_col = 16'($urandom);
          pend_row = 16'($urandom);
        end
        pend = 1'b1;
      end
      in_valid    = ($urandom_range(0, 99) < prob) && !(c >= gap_lo && c < gap_hi);
      in_col_word = pend_col;
      in_row_word = pend_row;
      if (in_valid && in_ready) begin
        acc_col.push_back(pend_col);
        acc_row.push_back(pend_row);
        pend = 1'b0;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_blocks  = '0;
    in_valid    = 1'b0;
    in_col_word = 16'd0;
    in_row_word = 16'd0;

    // reset held three cycles
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_tile_rst_n", tile_rst_n, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_underrun", underrun_cnt, 0);
    chk("reset_out_col_word", out_col_word, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_tile_rst_n", tile_rst_n, 1'b1);

    // single block 0x1234 / 0xABCD
    run_job(1, 100, 0, 0, 1'b1, -1, -1);
    // back-to-back three blocks, start pulsed while busy
    run_job(3, 100, 0, 0, 1'b0, 5, -1);
    // in_valid dropped for 6 cycles after block 0
    run_job(3, 100, TRC + 5, TRC + 11, 1'b0, -1, -1);
    // empty job, start pulsed during tile reset
    run_job(0, 100, 0, 0, 1'b0, 2, -1);
    // reset at phase 2 of block 1, then a fresh job
    run_job(3, 100, 0, 0, 1'b0, -1, TRC + 7);
    run_job(2, 100, 0, 0, 1'b1, -1, -1);
    // random jobs with sparse input
    for (int j = 0; j < 8; j++) begin
      int gl;
      gl = int'($urandom_range(0, 30));
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(30, 100)),
              gl, gl + int'($urandom_range(0, 10)), 1'b0, int'($urandom_range(1, 6)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
